// File: rtl/sort_pkg.sv
// Shared state encodings and the insertion compare used by the packet sorter.
package sort_pkg;

    localparam int unsigned CMP_W = 64;

    localparam logic [0:0] RECV = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    // True when slot value a must move up to make room for incoming word b.
    function automatic logic gt_sel(input logic [CMP_W-1:0] a,
                                    input logic [CMP_W-1:0] b,
                                    input logic             desc);
        return desc ? (a < b) : (a > b);
    endfunction

endpackage

// File: rtl/avst_insertion_sorter_if.sv
// Avalon-ST beat bundle; master drives a source, slave sits on a sink.
interface avst_insertion_sorter_if #(
    parameter int unsigned DWIDTH = 8
);
    logic [DWIDTH-1:0] data;
    logic              startofpacket;
    logic              endofpacket;
    logic              valid;
    logic              ready;

    modport master (output data, startofpacket, endofpacket, valid, input ready);
    modport slave  (input data, startofpacket, endofpacket, valid, output ready);
endinterface

// File: rtl/sort_insert_array.sv
// Register slots with one-cycle parallel shift-insert and a read mux on the next-state contents.
module sort_insert_array
    import sort_pkg::*;
#(
    parameter int unsigned DWIDTH      = 8,
    parameter int unsigned MAX_PKT_LEN = 16,
    parameter int unsigned CNT_W       = $clog2(MAX_PKT_LEN + 1)
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              clr,
    input  logic              ins,
    input  logic              desc,
    input  logic [CNT_W-1:0]  count,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic [CNT_W-1:0]  rd_idx,
    output logic [DWIDTH-1:0] rd_data
);

    logic [DWIDTH-1:0]      slots     [MAX_PKT_LEN];
    logic [DWIDTH-1:0]      slots_nxt [MAX_PKT_LEN];
    logic [MAX_PKT_LEN-1:0] ge_pos;
    logic [CNT_W-1:0]       eff_count;

    assign eff_count = clr ? '0 : count;

    // Slots are kept sorted, so the set of slots at/after the insert point is a contiguous top run.
    always_comb begin
        ge_pos = '0;
        for (int i = 0; i < int'(MAX_PKT_LEN); i++) begin
            ge_pos[i] = (CNT_W'(i) >= eff_count) ||
                        gt_sel(CMP_W'(slots[i]), CMP_W'(wr_data), desc);
        end
    end

    always_comb begin
        for (int j = 0; j < int'(MAX_PKT_LEN); j++) begin
            slots_nxt[j] = slots[j];
        end
        if (ins && ge_pos[0]) begin
            slots_nxt[0] = wr_data;
        end
        for (int j = 1; j < int'(MAX_PKT_LEN); j++) begin
            if (ins && ge_pos[j]) begin
                slots_nxt[j] = ge_pos[j-1] ? slots[j-1] : wr_data;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < int'(MAX_PKT_LEN); i++) begin
            if (rd_idx == CNT_W'(i)) begin
                rd_data = slots_nxt[i];
            end
        end
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            for (int i = 0; i < int'(MAX_PKT_LEN); i++) begin
                slots[i] <= '0;
            end
        end else begin
            slots <= slots_nxt;
        end
    end

endmodule

// File: rtl/avst_insertion_sorter.sv
// Avalon-ST packet sorter: inserts each received word in order, then streams the packet out.
module avst_insertion_sorter
    import sort_pkg::*;
#(
    parameter int unsigned DWIDTH      = 8,
    parameter int unsigned MAX_PKT_LEN = 16
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    descending_i,
    avst_insertion_sorter_if.slave  snk,
    avst_insertion_sorter_if.master src,
    output logic                    trunc_o
);

    localparam int unsigned CNT_W = $clog2(MAX_PKT_LEN + 1);

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  rd_idx_q, rd_idx_d;
    logic              open_q, open_d;
    logic              mode_q, mode_d;
    logic              trunc_flag_q, trunc_flag_d;
    logic              snk_ready_q, snk_ready_d;
    logic              src_valid_q, src_valid_d;
    logic              src_sop_q, src_sop_d;
    logic              src_eop_q, src_eop_d;
    logic [DWIDTH-1:0] src_data_q;
    logic              trunc_q, trunc_d;

    logic              beat;
    logic              ld_data;
    logic              arr_clr;
    logic              arr_ins;
    logic              arr_desc;
    logic [CNT_W-1:0]  rd_sel;
    logic [DWIDTH-1:0] rd_data;

    sort_insert_array #(
        .DWIDTH      (DWIDTH),
        .MAX_PKT_LEN (MAX_PKT_LEN),
        .CNT_W       (CNT_W)
    ) u_array (
        .clk     (clk),
        .srst    (srst),
        .clr     (arr_clr),
        .ins     (arr_ins),
        .desc    (arr_desc),
        .count   (count_q),
        .wr_data (snk.data),
        .rd_idx  (rd_sel),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        rd_idx_d     = rd_idx_q;
        open_d       = open_q;
        mode_d       = mode_q;
        trunc_flag_d = trunc_flag_q;
        snk_ready_d  = snk_ready_q;
        src_valid_d  = src_valid_q;
        src_sop_d    = src_sop_q;
        src_eop_d    = src_eop_q;
        trunc_d      = 1'b0;
        beat         = 1'b0;
        ld_data      = 1'b0;
        arr_clr      = 1'b0;
        arr_ins      = 1'b0;
        arr_desc     = mode_q;
        rd_sel       = rd_idx_q;

        case (state_q)
            RECV: begin
                snk_ready_d = 1'b1;
                beat        = snk.valid && snk_ready_q;
                if (beat && snk.startofpacket) begin
                    arr_clr      = 1'b1;
                    arr_ins      = 1'b1;
                    arr_desc     = descending_i;
                    count_d      = CNT_W'(1);
                    mode_d       = descending_i;
                    open_d       = 1'b1;
                    trunc_flag_d = 1'b0;
                end else if (beat && open_q) begin
                    if (count_q < CNT_W'(MAX_PKT_LEN)) begin
                        arr_ins = 1'b1;
                        count_d = count_q + CNT_W'(1);
                    end else begin
                        trunc_flag_d = 1'b1;
                    end
                end
                // Closing beat: first word comes straight from the post-insert slot contents.
                if (beat && snk.endofpacket && (snk.startofpacket || open_q)) begin
                    state_d      = SEND;
                    open_d       = 1'b0;
                    snk_ready_d  = 1'b0;
                    src_valid_d  = 1'b1;
                    src_sop_d    = 1'b1;
                    src_eop_d    = (count_d == CNT_W'(1));
                    rd_idx_d     = '0;
                    rd_sel       = '0;
                    ld_data      = 1'b1;
                    trunc_d      = trunc_flag_d;
                    trunc_flag_d = 1'b0;
                end
            end
            SEND: begin
                if (src_valid_q && src.ready) begin
                    if (src_eop_q) begin
                        state_d     = RECV;
                        count_d     = '0;
                        src_valid_d = 1'b0;
                        src_sop_d   = 1'b0;
                        src_eop_d   = 1'b0;
                        snk_ready_d = 1'b1;
                    end else begin
                        rd_idx_d  = rd_idx_q + CNT_W'(1);
                        rd_sel    = rd_idx_q + CNT_W'(1);
                        ld_data   = 1'b1;
                        src_sop_d = 1'b0;
                        src_eop_d = ((rd_idx_q + CNT_W'(1)) == (count_q - CNT_W'(1)));
                    end
                end
            end
            default: state_d = RECV;
        endcase
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state_q      <= RECV;
            count_q      <= '0;
            rd_idx_q     <= '0;
            open_q       <= 1'b0;
            mode_q       <= 1'b0;
            trunc_flag_q <= 1'b0;
            snk_ready_q  <= 1'b0;
            src_valid_q  <= 1'b0;
            src_sop_q    <= 1'b0;
            src_eop_q    <= 1'b0;
            src_data_q   <= '0;
            trunc_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            rd_idx_q     <= rd_idx_d;
            open_q       <= open_d;
            mode_q       <= mode_d;
            trunc_flag_q <= trunc_flag_d;
            snk_ready_q  <= snk_ready_d;
            src_valid_q  <= src_valid_d;
            src_sop_q    <= src_sop_d;
            src_eop_q    <= src_eop_d;
            trunc_q      <= trunc_d;
            if (ld_data) begin
                src_data_q <= rd_data;
            end
        end
    end

    assign snk.ready         = snk_ready_q;
    assign src.valid         = src_valid_q;
    assign src.startofpacket = src_sop_q;
    assign src.endofpacket   = src_eop_q;
    assign src.data          = src_data_q;
    assign trunc_o           = trunc_q;

endmodule

// File: tb/tb_avst_insertion_sorter.sv
// Directed bench for avst_insertion_sorter (DWIDTH=8, MAX_PKT_LEN=4).
module tb_avst_insertion_sorter;

    logic clk = 1'b0;
    logic srst = 1'b1;
    logic descending_i = 1'b0;
    logic trunc_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    avst_insertion_sorter_if #(.DWIDTH(8)) snk_if ();
    avst_insertion_sorter_if #(.DWIDTH(8)) src_if ();

    avst_insertion_sorter #(
        .DWIDTH      (8),
        .MAX_PKT_LEN (4)
    ) dut (
        .clk          (clk),
        .srst         (srst),
        .descending_i (descending_i),
        .snk          (snk_if),
        .src          (src_if),
        .trunc_o      (trunc_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offer one beat, wait for it to be taken; on EOP check the next-cycle outputs.
    task automatic push(input string tag, input logic [7:0] d, input logic sop, input logic eop,
                        input logic desc, input logic exp_vld, input logic exp_tr);
        int n = 0;
        @(negedge clk);
        snk_if.data          = d;
        snk_if.startofpacket = sop;
        snk_if.endofpacket   = eop;
        snk_if.valid         = 1'b1;
        descending_i         = desc;
        while (!snk_if.ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!snk_if.ready) check({tag, "_snk_timeout"}, 32'(snk_if.ready), 32'd1);
        @(posedge clk);
        #1;
        snk_if.valid         = 1'b0;
        snk_if.startofpacket = 1'b0;
        snk_if.endofpacket   = 1'b0;
        if (eop) begin
            check({tag, "_src_valid"}, 32'(src_if.valid), 32'(exp_vld));
            check({tag, "_trunc"}, 32'(trunc_o), 32'(exp_tr));
            if (exp_vld) check({tag, "_snk_ready_low"}, 32'(snk_if.ready), 32'd0);
        end
    endtask

    // Drain n output beats and compare against e0..e3; rnd applies random backpressure.
    task automatic collect(input string tag, input int n, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3, input logic rnd);
        logic [7:0] e [4];
        int   idx = 0;
        int   cyc = 0;
        logic stall = 1'b0;
        logic [7:0] pd = '0;
        logic ps = 1'b0;
        logic pe = 1'b0;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        while (idx < n && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (stall) begin
                check({tag, "_hold_valid"}, 32'(src_if.valid), 32'd1);
                check({tag, "_hold_data"}, 32'(src_if.data), 32'(pd));
                check({tag, "_hold_sop"}, 32'(src_if.startofpacket), 32'(ps));
                check({tag, "_hold_eop"}, 32'(src_if.endofpacket), 32'(pe));
            end
            src_if.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            check({tag, "_snk_ready_send"}, 32'(snk_if.ready), 32'd0);
            if (src_if.valid && src_if.ready) begin
                check({tag, "_data"}, 32'(src_if.data), 32'(e[idx]));
                check({tag, "_sop"}, 32'(src_if.startofpacket), 32'(idx == 0));
                check({tag, "_eop"}, 32'(src_if.endofpacket), 32'(idx == n - 1));
                idx++;
                stall = 1'b0;
            end else begin
                stall = src_if.valid;
                pd    = src_if.data;
                ps    = src_if.startofpacket;
                pe    = src_if.endofpacket;
            end
        end
        check({tag, "_beats"}, 32'(idx), 32'(n));
        if (!rnd) check({tag, "_cycles"}, 32'(cyc), 32'(n));
        @(posedge clk);
        #1;
        check({tag, "_valid_drop"}, 32'(src_if.valid), 32'd0);
        check({tag, "_trunc_idle"}, 32'(trunc_o), 32'd0);
        @(negedge clk);
        check({tag, "_snk_ready_back"}, 32'(snk_if.ready), 32'd1);
        src_if.ready = 1'b1;
    endtask

    initial begin
        snk_if.data          = '0;
        snk_if.startofpacket = 1'b0;
        snk_if.endofpacket   = 1'b0;
        snk_if.valid         = 1'b0;
        src_if.ready         = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_snk_ready", 32'(snk_if.ready), 32'd0);
        check("rst_src_valid", 32'(src_if.valid), 32'd0);
        check("rst_src_data", 32'(src_if.data), 32'd0);
        check("rst_trunc", 32'(trunc_o), 32'd0);
        srst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_release_ready", 32'(snk_if.ready), 32'd1);

        // Stray beat with no open packet is dropped.
        push("nosop", 8'hAA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("nosop_snk_ready", 32'(snk_if.ready), 32'd1);

        push("asc", 8'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push("asc", 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("asc", 8'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("asc", 8'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        collect("asc", 4, 8'd1, 8'd3, 8'd5, 8'd9, 1'b0);

        // Mode latched at SOP; later toggles ignored.
        push("desc", 8'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        push("desc", 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("desc", 8'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("desc", 8'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        collect("desc", 4, 8'd9, 8'd5, 8'd3, 8'd1, 1'b0);

        push("asc2", 8'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push("asc2", 8'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        push("asc2", 8'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        push("asc2", 8'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        collect("asc2", 4, 8'd1, 8'd3, 8'd5, 8'd9, 1'b0);

        push("single", 8'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        collect("single", 1, 8'd7, 8'd0, 8'd0, 8'd0, 1'b0);

        push("dup", 8'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push("dup", 8'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("dup", 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("dup", 8'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        collect("dup", 4, 8'd2, 8'd4, 8'd4, 8'd4, 1'b0);

        push("bp", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push("bp", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("bp", 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        collect("bp", 3, 8'h00, 8'h80, 8'hFF, 8'd0, 1'b1);

        // Six words into four slots: last two dropped, trunc pulses with the close.
        push("trunc", 8'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push("trunc", 8'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("trunc", 8'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("trunc", 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("trunc", 8'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("trunc", 8'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        collect("trunc", 4, 8'd5, 8'd6, 8'd7, 8'd8, 1'b0);

        push("restart", 8'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push("restart", 8'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("restart", 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push("restart", 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("restart", 8'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        collect("restart", 3, 8'd1, 8'd2, 8'd3, 8'd0, 1'b0);

        // Asynchronous reset in the middle of SEND.
        src_if.ready = 1'b0;
        push("arst", 8'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push("arst", 8'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        #2;
        srst = 1'b1;
        #1;
        check("arst_src_valid", 32'(src_if.valid), 32'd0);
        check("arst_snk_ready", 32'(snk_if.ready), 32'd0);
        check("arst_src_data", 32'(src_if.data), 32'd0);
        check("arst_src_sop", 32'(src_if.startofpacket), 32'd0);
        @(negedge clk);
        srst = 1'b0;
        src_if.ready = 1'b1;
        @(posedge clk);
        #1;
        check("arst_release_ready", 32'(snk_if.ready), 32'd1);
        push("post", 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push("post", 8'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        collect("post", 2, 8'd1, 8'd3, 8'd0, 8'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
